// File: rtl/dtc_vote_accum_pkg.sv
// Shared definitions for the decision-tree vote accumulator: sizes, leaf type,
// FSM states and width helpers.
package dtc_pkg;

  localparam int NBITS  = 10;
  localparam int WINDOW = 16;

  function automatic int cw_of(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int iw_of(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

  localparam int CW = cw_of(WINDOW);
  localparam int IW = iw_of(NBITS);

  typedef logic [NBITS-1:0] leaf_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dtc_vote_accum_if.sv
// Leaf-vector input stream plus flush, and the argmax result stream.
interface dtc_vote_accum_if #(
  parameter int NBITS  = dtc_pkg::NBITS,
  parameter int WINDOW = dtc_pkg::WINDOW
);
  import dtc_pkg::*;

  localparam int CW = cw_of(WINDOW);
  localparam int IW = iw_of(NBITS);

  logic [NBITS-1:0] inp;
  logic             inp_valid;
  logic             inp_ready;
  logic             flush;
  logic [IW-1:0]    outp_idx;
  logic [CW-1:0]    outp_cnt;
  logic [CW-1:0]    outp_nsamp;
  logic             outp_valid;
  logic             outp_ready;

  modport master (
    output inp, inp_valid, flush, outp_ready,
    input  inp_ready, outp_idx, outp_cnt, outp_nsamp, outp_valid
  );

  modport slave (
    input  inp, inp_valid, flush, outp_ready,
    output inp_ready, outp_idx, outp_cnt, outp_nsamp, outp_valid
  );

endinterface

// File: rtl/dtc_vote_accum_argmax_step.sv
// One lane of the sequential argmax: strict greater-than, so ties keep the
// earlier (lower) index. 'first' seeds the running best from lane 0.
module dtc_argmax_step #(
  parameter int CW = dtc_pkg::CW,
  parameter int IW = dtc_pkg::IW
) (
  input  logic          first,
  input  logic [CW-1:0] lane_cnt,
  input  logic [IW-1:0] lane_idx,
  input  logic [CW-1:0] best_cnt,
  input  logic [IW-1:0] best_idx,
  output logic [CW-1:0] next_cnt,
  output logic [IW-1:0] next_idx
);

  always_comb begin
    next_cnt = best_cnt;
    next_idx = best_idx;
    if (first || (lane_cnt > best_cnt)) begin
      next_cnt = lane_cnt;
      next_idx = lane_idx;
    end
  end

endmodule

// File: rtl/dtc_vote_accum.sv
// Accumulates per-bit votes over a window of leaf vectors, then scans one lane
// per cycle for the argmax and holds the result on a valid/ready output.
module dtc_vote_accum #(
  parameter int NBITS  = dtc_pkg::NBITS,
  parameter int WINDOW = dtc_pkg::WINDOW
) (
  input  logic            clk,
  input  logic            rst,
  dtc_vote_accum_if.slave bus
);
  import dtc_pkg::*;

  localparam int CW = cw_of(WINDOW);
  localparam int IW = iw_of(NBITS);
  localparam logic [CW-1:0] WINDOW_C  = CW'(WINDOW);
  localparam logic [IW-1:0] LAST_LANE = IW'(NBITS - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg [NBITS];
  logic [CW-1:0] nsamp_reg, nsamp_next;
  logic [IW-1:0] k_reg;
  logic [CW-1:0] best_cnt_reg;
  logic [IW-1:0] best_idx_reg;
  logic [CW-1:0] lane_cnt, step_cnt;
  logic [IW-1:0] step_idx;
  logic [IW-1:0] outp_idx_reg;
  logic [CW-1:0] outp_cnt_reg, outp_nsamp_reg;
  logic          accept, close_window, scan_last, out_fire;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ACCUM;
    else     state_reg <= state_next;
  end

  // A flush closes the window whenever it would hold at least one sample,
  // counting a sample accepted in the same cycle.
  always_comb begin
    state_next     = state_reg;
    accept         = 1'b0;
    close_window   = 1'b0;
    scan_last      = 1'b0;
    out_fire       = 1'b0;
    nsamp_next     = nsamp_reg;
    bus.inp_ready  = 1'b0;
    bus.outp_valid = 1'b0;
    case (state_reg)
      ACCUM: begin
        bus.inp_ready = 1'b1;
        accept        = bus.inp_valid;
        nsamp_next    = nsamp_reg + CW'(accept);
        close_window  = (accept && (nsamp_next == WINDOW_C)) ||
                        (bus.flush && (nsamp_next != '0));
        if (close_window) state_next = SCAN;
      end
      SCAN: begin
        scan_last = (k_reg == LAST_LANE);
        if (scan_last) state_next = DONE;
      end
      DONE: begin
        bus.outp_valid = 1'b1;
        out_fire       = bus.outp_ready;
        if (out_fire) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || out_fire) begin
      for (int i = 0; i < NBITS; i++) cnt_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NBITS; i++) cnt_reg[i] <= cnt_reg[i] + CW'(bus.inp[i]);
    end
  end

  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (k_reg == IW'(i)) lane_cnt = cnt_reg[i];
    end
  end

  dtc_argmax_step #(.CW(CW), .IW(IW)) u_step (
    .first    (k_reg == '0),
    .lane_cnt (lane_cnt),
    .lane_idx (k_reg),
    .best_cnt (best_cnt_reg),
    .best_idx (best_idx_reg),
    .next_cnt (step_cnt),
    .next_idx (step_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      nsamp_reg      <= '0;
      k_reg          <= '0;
      best_cnt_reg   <= '0;
      best_idx_reg   <= '0;
      outp_idx_reg   <= '0;
      outp_cnt_reg   <= '0;
      outp_nsamp_reg <= '0;
    end else begin
      if (state_reg == ACCUM) begin
        nsamp_reg <= nsamp_next;
        if (close_window) k_reg <= '0;
      end
      if (state_reg == SCAN) begin
        best_cnt_reg <= step_cnt;
        best_idx_reg <= step_idx;
        k_reg        <= k_reg + IW'(1);
        if (scan_last) begin
          outp_idx_reg   <= step_idx;
          outp_cnt_reg   <= step_cnt;
          outp_nsamp_reg <= nsamp_reg;
        end
      end
      if (out_fire) begin
        nsamp_reg <= '0;
        k_reg     <= '0;
      end
    end
  end

  assign bus.outp_idx   = outp_idx_reg;
  assign bus.outp_cnt   = outp_cnt_reg;
  assign bus.outp_nsamp = outp_nsamp_reg;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Bench for dtc_vote_accum: directed windows with literal results, then random
// traffic, all compared every cycle against a window-level vote model.
module tb_dtc_vote_accum;
  import dtc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dtc_vote_accum_if bus ();

  dtc_vote_accum dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: vote totals of the open window, remaining scan cycles, pending result.
  int votes [NBITS];
  int n_m   = 0;
  int busy  = 0;
  bit pend  = 1'b0;
  int e_idx = 0;
  int e_cnt = 0;
  int e_n   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBITS; i++) votes[i] = 0;
    n_m = 0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_clear();
      busy = 0;
      pend = 1'b0;
    end else if (pend) begin
      if (bus.outp_ready) begin
        pend = 1'b0;
        model_clear();
      end
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) pend = 1'b1;
    end else begin
      bit acc;
      acc = bus.inp_valid;
      if (acc) begin
        for (int i = 0; i < NBITS; i++) votes[i] += int'(bus.inp[i]);
        n_m++;
      end
      if ((acc && n_m == WINDOW) || (bus.flush && n_m > 0)) begin
        e_idx = 0;
        e_cnt = 0;
        for (int i = 0; i < NBITS; i++) begin
          if (votes[i] > e_cnt) begin
            e_cnt = votes[i];
            e_idx = i;
          end
        end
        e_n  = n_m;
        busy = NBITS;
      end
    end
  endtask

  task automatic compare();
    chk("inp_ready", int'(bus.inp_ready), int'(busy == 0 && !pend));
    chk("outp_valid", int'(bus.outp_valid), int'(pend));
    if (pend) begin
      chk("outp_idx", int'(bus.outp_idx), e_idx);
      chk("outp_cnt", int'(bus.outp_cnt), e_cnt);
      chk("outp_nsamp", int'(bus.outp_nsamp), e_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input leaf_t vec, input int count, input bit flush_last);
    for (int i = 0; i < count; i++) begin
      bus.inp       = vec;
      bus.inp_valid = 1'b1;
      bus.flush     = flush_last && (i == count - 1);
      tick();
    end
    bus.inp_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // Called right after the closing accept/flush: checks latency and result, then consumes it.
  task automatic wait_result(input string name, input int idx, input int cnt, input int n);
    int lat;
    lat = 0;
    while (!bus.outp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, NBITS);
    chk({name, "_idx"}, int'(bus.outp_idx), idx);
    chk({name, "_cnt"}, int'(bus.outp_cnt), cnt);
    chk({name, "_nsamp"}, int'(bus.outp_nsamp), n);
    bus.outp_ready = 1'b1;
    tick();
    bus.outp_ready = 1'b0;
    chk({name, "_consumed"}, int'(bus.outp_valid), 0);
  endtask

  initial begin
    model_clear();
    bus.inp        = '0;
    bus.inp_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.outp_ready = 1'b0;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_inp_ready", int'(bus.inp_ready), 1);
    chk("reset_outp_valid", int'(bus.outp_valid), 0);
    chk("reset_outp_idx", int'(bus.outp_idx), 0);
    chk("reset_outp_cnt", int'(bus.outp_cnt), 0);
    chk("reset_outp_nsamp", int'(bus.outp_nsamp), 0);
    tick();

    send(leaf_t'(10'b0000000100), 16, 1'b0);
    wait_result("s1", 2, 16, 16);

    send(leaf_t'(10'b1000000001), 8, 1'b0);
    send(leaf_t'(10'b0000000001), 8, 1'b0);
    wait_result("s2", 0, 16, 16);
    send(leaf_t'(10'b1000000001), 16, 1'b0);
    wait_result("s2_tie", 0, 16, 16);

    send(leaf_t'(10'b0010000000), 6, 1'b1);
    wait_result("s3", 7, 6, 6);

    // Result held under backpressure; input pulses and flushes must be ignored.
    send(leaf_t'(10'b0000010000), 16, 1'b0);
    for (int i = 0; i < NBITS + 20; i++) begin
      bus.inp       = leaf_t'($urandom);
      bus.inp_valid = ($urandom_range(0, 1) == 1);
      bus.flush     = ($urandom_range(0, 3) == 0);
      tick();
    end
    bus.inp_valid = 1'b0;
    bus.flush     = 1'b0;
    chk("s4_hold_valid", int'(bus.outp_valid), 1);
    chk("s4_hold_ready", int'(bus.inp_ready), 0);
    chk("s4_hold_idx", int'(bus.outp_idx), 4);
    chk("s4_hold_cnt", int'(bus.outp_cnt), 16);
    bus.outp_ready = 1'b1;
    tick();
    bus.outp_ready = 1'b0;

    bus.flush = 1'b1;
    tick();
    tick();
    bus.flush = 1'b0;
    tick();
    chk("s5_empty_flush_valid", int'(bus.outp_valid), 0);
    chk("s5_empty_flush_ready", int'(bus.inp_ready), 1);
    send(leaf_t'(10'b0000000000), 16, 1'b0);
    wait_result("s5", 0, 0, 16);

    // Reset during scan lane 4 must discard the partial window.
    send(leaf_t'(10'b0000000001), 16, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_rst_valid", int'(bus.outp_valid), 0);
    chk("s6_rst_ready", int'(bus.inp_ready), 1);
    for (int i = 0; i < 15; i++) tick();
    chk("s6_no_late_valid", int'(bus.outp_valid), 0);
    send(leaf_t'(10'b0100000000), 16, 1'b0);
    wait_result("s6", 8, 16, 16);

    for (int c = 0; c < 3000; c++) begin
      bus.inp        = leaf_t'($urandom) & leaf_t'($urandom);
      bus.inp_valid  = ($urandom_range(0, 9) < 7);
      bus.flush      = ($urandom_range(0, 19) == 0);
      bus.outp_ready = ($urandom_range(0, 1) == 1);
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst            = 1'b0;
    bus.inp_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.outp_ready = 1'b1;
    for (int i = 0; i < NBITS + 4; i++) tick();
    chk("drain_idle_ready", int'(bus.inp_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
